// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - 4-bit operation codes (OP_AND .. OP_DIVU); codes above OP_DIVU are illegal
//   - FSM state encoding (S_IDLE, S_ITER, S_EXEC)
//   - flag bundle carried from the datapath to the output registers
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_NOR  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0101;
    localparam logic [3:0] OP_SLT  = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_EXEC = 2'd2
    } state_t;

    typedef struct packed {
        logic zero;
        logic negative;
        logic carry;
        logic overflow;
        logic div_zero;
        logic illegal;
    } flags_t;

endpackage

// File: rtl/seq_alu_if.sv
// seq_alu_if: start/done handshake, operands and results of the sequential ALU.
//   master: drives start/op/a/b, observes busy/done/results/flags
//   slave : the ALU side
interface seq_alu_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
    logic             negative;
    logic             carry;
    logic             overflow;
    logic             div_zero;
    logic             illegal;

    modport master (
        output start, op, a, b,
        input  busy, done, result, result_hi,
        input  zero, negative, carry, overflow, div_zero, illegal
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, result_hi,
        output zero, negative, carry, overflow, div_zero, illegal
    );
endinterface

// File: rtl/alu_iter_core.sv
// alu_iter_core: shift/accumulate engine for MULU (shift-add, LSB first) and
// DIVU (restoring, MSB first), one bit per step, WIDTH steps per operation.
//   clk, rst : clock, async active-high reset
//   mode     : 0 = multiply, 1 = divide (captured on load)
//   load     : capture a/b and arm the counter at WIDTH-1
//   step     : advance one iteration
//   a, b     : multiplier/dividend, multiplicand/divisor
//   last     : counter is 0, the current step is the final one
//   hi, lo   : register contents after the current step (product hi/lo or
//              remainder/quotient once the final step is taken)
module alu_iter_core #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic             mode_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] opnd_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH:0]   msum;
    logic [WIDTH:0]   dshift;
    logic [WIDTH:0]   ddiff;
    logic [WIDTH-1:0] hi_s;
    logic [WIDTH-1:0] lo_s;

    // One iteration of the selected algorithm, exposed so the caller can
    // capture the final value on the same edge that performs the last step.
    always_comb begin
        hi_s   = hi_q;
        lo_s   = lo_q;
        msum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        dshift = {hi_q, lo_q[WIDTH-1]};
        // Remainder stays below the divisor, so bit WIDTH of the difference is the borrow.
        ddiff  = dshift - {1'b0, opnd_q};
        if (mode_q) begin
            hi_s = ddiff[WIDTH] ? dshift[WIDTH-1:0] : ddiff[WIDTH-1:0];
            lo_s = {lo_q[WIDTH-2:0], ~ddiff[WIDTH]};
        end else begin
            {hi_s, lo_s} = {msum, lo_q[WIDTH-1:1]};
        end
    end

    // Working registers and iteration counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
        end else if (load) begin
            mode_q <= mode;
            hi_q   <= '0;
            lo_q   <= a;
            opnd_q <= b;
            cnt_q  <= CNT_W'(WIDTH - 1);
        end else if (step) begin
            hi_q <= hi_s;
            lo_q <= lo_s;
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign last = (cnt_q == '0);
    assign hi   = hi_s;
    assign lo   = lo_s;

endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with start/done handshake and registered flags.
//   clk, rst : clock, async active-high reset
//   bus      : seq_alu_if slave -- start/op/a/b in; busy/done/result/
//              result_hi/zero/negative/carry/overflow/div_zero/illegal out
// Single-cycle ops (and DIVU by zero, illegal ops) finish one cycle after
// start; MULU and DIVU iterate WIDTH cycles in alu_iter_core first.
module seq_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    seq_alu_if.slave   bus
);
    state_t           state_q, state_d;
    logic             load_c, step_c, cap_c, last_c, iter_op_c;
    logic [WIDTH-1:0] core_hi, core_lo;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH-1:0] b_eff;
    logic             is_sub;
    logic [WIDTH-1:0] sc_res, sc_hi;
    flags_t           sc_flg;

    logic [WIDTH-1:0] res_d, hi_d;
    flags_t           flg_d;
    logic [WIDTH-1:0] res_q, hi_q;
    flags_t           flg_q;
    logic             done_q, busy_q;

    alu_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk  (clk),
        .rst  (rst),
        .mode (bus.op == OP_DIVU),
        .load (load_c),
        .step (step_c),
        .a    (bus.a),
        .b    (bus.b),
        .last (last_c),
        .hi   (core_hi),
        .lo   (core_lo)
    );

    assign iter_op_c = (bus.op == OP_MULU) || ((bus.op == OP_DIVU) && (bus.b != '0));

    // Single-cycle datapath; ADD and SUB share one WIDTH+1 adder
    always_comb begin
        sc_res  = '0;
        sc_hi   = '0;
        sc_flg  = '0;
        is_sub  = (bus.op == OP_SUB);
        b_eff   = is_sub ? ~bus.b : bus.b;
        add_sum = {1'b0, bus.a} + {1'b0, b_eff} + (WIDTH + 1)'(is_sub);
        case (bus.op)
            OP_AND:  sc_res = bus.a & bus.b;
            OP_OR:   sc_res = bus.a | bus.b;
            OP_NOR:  sc_res = ~(bus.a | bus.b);
            OP_XOR:  sc_res = bus.a ^ bus.b;
            OP_ADD, OP_SUB: begin
                sc_res          = add_sum[WIDTH-1:0];
                sc_flg.carry    = add_sum[WIDTH];
                sc_flg.overflow = (bus.a[WIDTH-1] == b_eff[WIDTH-1]) &&
                                  (add_sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SLT:  sc_res = WIDTH'($signed(bus.a) < $signed(bus.b));
            OP_SLTU: sc_res = WIDTH'(bus.a < bus.b);
            OP_MULU: sc_res = '0;
            // Only reaches this path with b == 0
            OP_DIVU: begin
                sc_res          = '1;
                sc_hi           = bus.a;
                sc_flg.div_zero = 1'b1;
            end
            default: sc_flg.illegal = 1'b1;
        endcase
        if (!sc_flg.illegal) begin
            sc_flg.zero     = (sc_res == '0);
            sc_flg.negative = sc_res[WIDTH-1];
        end
    end

    // Next-state and capture control
    always_comb begin
        state_d = state_q;
        load_c  = 1'b0;
        step_c  = 1'b0;
        cap_c   = 1'b0;
        res_d   = sc_res;
        hi_d    = sc_hi;
        flg_d   = sc_flg;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (iter_op_c) begin
                        load_c  = 1'b1;
                        state_d = S_ITER;
                    end else begin
                        cap_c   = 1'b1;
                        state_d = S_EXEC;
                    end
                end
            end
            S_ITER: begin
                step_c = 1'b1;
                if (last_c) begin
                    cap_c          = 1'b1;
                    state_d        = S_EXEC;
                    res_d          = core_lo;
                    hi_d           = core_hi;
                    flg_d          = '0;
                    flg_d.zero     = (core_lo == '0);
                    flg_d.negative = core_lo[WIDTH-1];
                end
            end
            S_EXEC:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; results are captured on the edge entering EXEC
    // so done and the new values appear together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            res_q   <= '0;
            hi_q    <= '0;
            flg_q   <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= cap_c;
            busy_q  <= (state_d != S_IDLE);
            if (cap_c) begin
                res_q <= res_d;
                hi_q  <= hi_d;
                flg_q <= flg_d;
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result    = res_q;
    assign bus.result_hi = hi_q;
    assign bus.zero      = flg_q.zero;
    assign bus.negative  = flg_q.negative;
    assign bus.carry     = flg_q.carry;
    assign bus.overflow  = flg_q.overflow;
    assign bus.div_zero  = flg_q.div_zero;
    assign bus.illegal   = flg_q.illegal;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed and random operations on a 16-bit seq_alu; expected
// results are queued at start and compared when done rises.
module tb_seq_alu;
    import alu_pkg::*;

    localparam int unsigned W = 16;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic [5:0]   flg;   // {zero, negative, carry, overflow, div_zero, illegal}
        int           lat;
    } exp_t;

    logic clk;
    logic rst;
    int   vectors;
    int   errs;
    exp_t sb[$];

    seq_alu_if #(.WIDTH(W)) bus ();

    seq_alu #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t        e;
        int          s;
        int          ss;
        logic [31:0] p;
        logic        z, n, c, v, dz, il;
        e.res = '0; e.hi = '0; e.lat = 1;
        c = 1'b0; v = 1'b0; dz = 1'b0; il = 1'b0;
        case (o)
            OP_AND:  e.res = x & y;
            OP_OR:   e.res = x | y;
            OP_NOR:  e.res = ~(x | y);
            OP_XOR:  e.res = x ^ y;
            OP_ADD: begin
                s  = int'(x) + int'(y);
                ss = int'($signed(x)) + int'($signed(y));
                e.res = 16'(s);
                c = (s > 65535);
                v = (ss > 32767) || (ss < -32768);
            end
            OP_SUB: begin
                ss = int'($signed(x)) - int'($signed(y));
                e.res = x - y;
                c = (x >= y);
                v = (ss > 32767) || (ss < -32768);
            end
            OP_SLT:  e.res = ($signed(x) < $signed(y)) ? 16'd1 : 16'd0;
            OP_SLTU: e.res = (x < y) ? 16'd1 : 16'd0;
            OP_MULU: begin
                p = 32'(x) * 32'(y);
                e.res = p[15:0];
                e.hi  = p[31:16];
                e.lat = 17;
            end
            OP_DIVU: begin
                if (y == 16'd0) begin
                    e.res = 16'hFFFF;
                    e.hi  = x;
                    dz    = 1'b1;
                end else begin
                    e.res = x / y;
                    e.hi  = x % y;
                    e.lat = 17;
                end
            end
            default: il = 1'b1;
        endcase
        z = il ? 1'b0 : (e.res == 16'd0);
        n = il ? 1'b0 : e.res[15];
        e.flg = {z, n, c, v, dz, il};
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] flags_now();
        return {bus.zero, bus.negative, bus.carry, bus.overflow, bus.div_zero, bus.illegal};
    endfunction

    // Launch one op, optionally pulse a stray ADD start at cycle inject_at, then
    // wait (bounded) for done and compare against the queued expectation.
    task automatic issue(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input int inject_at);
        exp_t e;
        int   lat;
        sb.push_back(model(o, x, y));
        bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.op = 4'($urandom); bus.a = 16'($urandom); bus.b = 16'($urandom);
        lat = 1;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (lat == inject_at) begin
                bus.start = 1'b1; bus.op = OP_ADD; bus.a = 16'd1; bus.b = 16'd1;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            lat++;
        end
        e = sb.pop_front();
        chk({tag, ".latency"}, 32'(lat), 32'(e.lat));
        chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
        chk({tag, ".result"}, 32'(bus.result), 32'(e.res));
        chk({tag, ".result_hi"}, 32'(bus.result_hi), 32'(e.hi));
        chk({tag, ".flags"}, 32'(flags_now()), 32'(e.flg));
        @(posedge clk); #1;
        chk({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
        chk({tag, ".idle"}, 32'(bus.busy), 32'd0);
        chk({tag, ".hold"}, 32'(bus.result), 32'(e.res));
    endtask

    initial begin
        int dcnt;
        vectors = 0;
        errs    = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.busy", 32'(bus.busy), 32'd0);
        chk("reset.done", 32'(bus.done), 32'd0);
        chk("reset.result", 32'(bus.result), 32'd0);
        chk("reset.result_hi", 32'(bus.result_hi), 32'd0);
        chk("reset.flags", 32'(flags_now()), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        issue("add_ovf",   OP_ADD,  16'h7FFF, 16'h0001, 0);
        issue("sub_zero",  OP_SUB,  16'h0005, 16'h0005, 0);
        issue("slt",       OP_SLT,  16'hFFFF, 16'h0001, 0);
        issue("sltu",      OP_SLTU, 16'hFFFF, 16'h0001, 0);
        issue("mulu",      OP_MULU, 16'h1234, 16'h0010, 0);
        issue("mulu_max",  OP_MULU, 16'hFFFF, 16'hFFFF, 0);
        issue("divu",      OP_DIVU, 16'd100,  16'd7,    0);
        issue("divu_zero", OP_DIVU, 16'h1234, 16'h0000, 0);
        issue("divu_drop", OP_DIVU, 16'd100,  16'd7,    5);
        issue("illegal",   4'b1100, 16'hABCD, 16'h1234, 0);
        issue("sub_borrow", OP_SUB, 16'h8000, 16'h0001, 0);
        issue("nor",       OP_NOR,  16'h0F0F, 16'h00FF, 0);

        // Reset in the middle of a multiply
        bus.start = 1'b1; bus.op = OP_MULU; bus.a = 16'h1234; bus.b = 16'h0010;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid.busy", 32'(bus.busy), 32'd0);
        chk("rst_mid.done", 32'(bus.done), 32'd0);
        chk("rst_mid.result", 32'(bus.result), 32'd0);
        chk("rst_mid.result_hi", 32'(bus.result_hi), 32'd0);
        chk("rst_mid.flags", 32'(flags_now()), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) dcnt++;
        end
        chk("rst_mid.no_done", 32'(dcnt), 32'd0);
        issue("add_after_rst", OP_ADD, 16'd2, 16'd3, 0);

        for (int i = 0; i < 24; i++) begin
            logic [3:0] ro;
            ro = 4'($urandom_range(0, 11));
            issue("random", ro, 16'($urandom), (i % 6 == 5) ? 16'd0 : 16'($urandom), 0);
        end

        chk("scoreboard.empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
